// File: rtl/run_ctrl.sv
// run_ctrl: run/halt/single-step sequencer for the puzzle-solver CPU.
// Debounces the raw run and step buttons, sequences IDLE/RUN/STEP/DONE/FAULT,
// and produces cpu_en, which gates the decoder write enables. Execution stops
// when the register file raises comp or when the enabled-cycle budget runs out.

// Per-button conditioner: two-flop synchronizer, mismatch-count debounce, and
// a one-cycle pulse on each accepted rising level (releases give no pulse).
module run_ctrl_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          stable_d_r;
    logic [DW-1:0] dcnt_r;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive mismatching samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b0;
            dcnt_r   <= '0;
        end else if (sync2_r == stable_r) begin
            dcnt_r   <= '0;
        end else if (dcnt_r == DEB_MAX) begin
            stable_r <= sync2_r;
            dcnt_r   <= '0;
        end else begin
            dcnt_r   <= dcnt_r + DW'(1);
        end
    end

    // Delayed copy of the accepted level, used for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_d_r <= 1'b0;
        end else begin
            stable_d_r <= stable_r;
        end
    end

    // The pulse is decoded from two registers, so it is glitch-free.
    assign press = stable_r & ~stable_d_r;

endmodule

module run_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             clr,
    input  logic             comp,
    output logic             cpu_en,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] step_cnt,
    output logic             done,
    output logic             fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Count value during the last permitted enabled cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state_r;
    logic [CNT_W-1:0] step_cnt_r;
    logic             done_r;
    logic             fault_r;
    logic             run_pr_s;
    logic             step_pr_s;
    logic             cpu_en_s;
    logic             at_limit_s;

    run_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_run),
        .press (run_pr_s)
    );

    run_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .press (step_pr_s)
    );

    // comp must cut the enable in the same cycle, so this path is combinational
    // from the state register and comp.
    assign cpu_en_s   = ((state_r == ST_RUN) || (state_r == ST_STEP)) && !comp;
    assign at_limit_s = (step_cnt_r == LAST_CNT);

    // Sequencer: state, enabled-cycle counter and the decoded status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            step_cnt_r <= '0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
        end else if (clr) begin
            // clr beats comp and timeout; a count from this cycle is dropped.
            state_r    <= ST_IDLE;
            step_cnt_r <= '0;
            done_r     <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            if (cpu_en_s) begin
                step_cnt_r <= step_cnt_r + CNT_W'(1);
            end else begin
                step_cnt_r <= step_cnt_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (run_pr_s) begin
                        state_r <= ST_RUN;
                    end else if (step_pr_s) begin
                        state_r <= ST_STEP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (comp) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (at_limit_s) begin
                        // comp is low here, so this cycle is enabled.
                        state_r <= ST_FAULT;
                        fault_r <= 1'b1;
                    end else if (run_pr_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (comp) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else if (at_limit_s) begin
                        state_r <= ST_FAULT;
                        fault_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                ST_FAULT: begin
                    state_r <= ST_FAULT;
                end
                default: begin
                    // Illegal encoding: park safely with execution disabled.
                    state_r <= ST_FAULT;
                    done_r  <= 1'b0;
                    fault_r <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_en   = cpu_en_s;
    assign state    = state_r;
    assign step_cnt = step_cnt_r;
    assign done     = done_r;
    assign fault    = fault_r;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed bench for run_ctrl with DEB_CYCLES=4, TIMEOUT=50.
module tb_run_ctrl;

    logic        clk;
    logic        rst_n;
    logic        btn_run;
    logic        btn_step;
    logic        clr;
    logic        comp;
    logic        cpu_en;
    logic [2:0]  state;
    logic [15:0] step_cnt;
    logic        done;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    run_ctrl #(.DEB_CYCLES(4), .CNT_W(16), .TIMEOUT(50)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .clr      (clr),
        .comp     (comp),
        .cpu_en   (cpu_en),
        .state    (state),
        .step_cnt (step_cnt),
        .done     (done),
        .fault    (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise the buttons and wait 7 edges: the FSM has acted on the press.
    task automatic press_and_hold(input logic r, input logic s);
        btn_run  = r;
        btn_step = s;
        repeat (7) tick();
    endtask

    task automatic release_btns();
        btn_run  = 1'b0;
        btn_step = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
        n_checks++; if (step_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", step_cnt); end
        n_checks++; if (done !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got done=%b fault=%b want 0/0", done, fault); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_debounce();
        // 3-cycle glitch must be rejected.
        btn_run = 1'b1;
        repeat (3) tick();
        btn_run = 1'b0;
        repeat (10) tick();
        n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL deb_glitch: got state %0d want 0", state); end
        // Held press: RUN exactly after edge 7.
        btn_run = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i < 7) begin
                n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL deb_early e%0d: got state %0d want 0", i, state); end
            end
            if (i == 7) begin
                n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL deb_edge7: got state %0d want 1", state); end
            end
        end
        btn_run = 1'b0;
        repeat (10) tick();
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL deb_single_event: got state %0d want 1", state); end
        n_checks++; if (step_cnt !== 16'd13) begin n_fail++; $display("FAIL deb_run_cnt: got %0d want 13", step_cnt); end
        do_clr();
        n_checks++; if (state !== 3'd0 || step_cnt !== 16'd0) begin n_fail++; $display("FAIL deb_clr: got state %0d cnt %0d want 0/0", state, step_cnt); end
    endtask

    task automatic test_step();
        press_and_hold(1'b0, 1'b1);
        n_checks++; if (state !== 3'd2 || cpu_en !== 1'b1) begin n_fail++; $display("FAIL step_enter: got state %0d en %b want 2/1", state, cpu_en); end
        tick();
        n_checks++; if (state !== 3'd0 || cpu_en !== 1'b0) begin n_fail++; $display("FAIL step_return: got state %0d en %b want 0/0", state, cpu_en); end
        n_checks++; if (step_cnt !== 16'd1) begin n_fail++; $display("FAIL step_cnt1: got %0d want 1", step_cnt); end
        release_btns();
        n_checks++; if (step_cnt !== 16'd1) begin n_fail++; $display("FAIL step_hold_once: got %0d want 1", step_cnt); end
        for (int k = 0; k < 2; k++) begin
            press_and_hold(1'b0, 1'b1);
            release_btns();
        end
        n_checks++; if (step_cnt !== 16'd3 || state !== 3'd0) begin n_fail++; $display("FAIL step_cnt3: got cnt %0d state %0d want 3/0", step_cnt, state); end
    endtask

    task automatic test_run_comp();
        do_clr();
        press_and_hold(1'b1, 1'b0);
        btn_run = 1'b0;
        repeat (25) tick();
        n_checks++; if (step_cnt !== 16'd25 || cpu_en !== 1'b1) begin n_fail++; $display("FAIL comp_pre: got cnt %0d en %b want 25/1", step_cnt, cpu_en); end
        comp = 1'b1;
        #1;
        n_checks++; if (cpu_en !== 1'b0) begin n_fail++; $display("FAIL comp_same_cycle: got en %b want 0", cpu_en); end
        tick();
        n_checks++; if (state !== 3'd3 || done !== 1'b1) begin n_fail++; $display("FAIL comp_done: got state %0d done %b want 3/1", state, done); end
        n_checks++; if (step_cnt !== 16'd25) begin n_fail++; $display("FAIL comp_cnt: got %0d want 25", step_cnt); end
        comp = 1'b0;
        press_and_hold(1'b1, 1'b1);
        release_btns();
        n_checks++; if (state !== 3'd3 || step_cnt !== 16'd25 || cpu_en !== 1'b0) begin n_fail++; $display("FAIL done_hold: got state %0d cnt %0d en %b want 3/25/0", state, step_cnt, cpu_en); end
        do_clr();
        n_checks++; if (state !== 3'd0 || done !== 1'b0) begin n_fail++; $display("FAIL done_clr: got state %0d done %b want 0/0", state, done); end
    endtask

    task automatic test_clr_priority();
        press_and_hold(1'b1, 1'b0);
        btn_run = 1'b0;
        repeat (5) tick();
        comp = 1'b1;
        clr  = 1'b1;
        tick();
        comp = 1'b0;
        clr  = 1'b0;
        n_checks++; if (state !== 3'd0 || step_cnt !== 16'd0 || done !== 1'b0) begin n_fail++; $display("FAIL clr_over_comp: got state %0d cnt %0d done %b want 0/0/0", state, step_cnt, done); end
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        press_and_hold(1'b1, 1'b0);
        btn_run = 1'b0;
        repeat (49) tick();
        n_checks++; if (state !== 3'd1 || step_cnt !== 16'd49) begin n_fail++; $display("FAIL to_pre: got state %0d cnt %0d want 1/49", state, step_cnt); end
        tick();
        n_checks++; if (state !== 3'd4 || fault !== 1'b1) begin n_fail++; $display("FAIL to_fault: got state %0d fault %b want 4/1", state, fault); end
        n_checks++; if (step_cnt !== 16'd50 || cpu_en !== 1'b0) begin n_fail++; $display("FAIL to_cnt: got cnt %0d en %b want 50/0", step_cnt, cpu_en); end
        press_and_hold(1'b1, 1'b0);
        release_btns();
        n_checks++; if (state !== 3'd4 || step_cnt !== 16'd50) begin n_fail++; $display("FAIL to_hold: got state %0d cnt %0d want 4/50", state, step_cnt); end
        do_clr();
        n_checks++; if (state !== 3'd0 || step_cnt !== 16'd0 || fault !== 1'b0) begin n_fail++; $display("FAIL to_clr: got state %0d cnt %0d fault %b want 0/0/0", state, step_cnt, fault); end
    endtask

    task automatic test_pause();
        press_and_hold(1'b1, 1'b0);
        btn_run = 1'b0;
        repeat (10) tick();
        n_checks++; if (step_cnt !== 16'd10) begin n_fail++; $display("FAIL pause_pre: got %0d want 10", step_cnt); end
        // 6 more enabled edges during debounce, plus the edge that samples run_pr.
        press_and_hold(1'b1, 1'b0);
        n_checks++; if (state !== 3'd0 || step_cnt !== 16'd17) begin n_fail++; $display("FAIL pause_idle: got state %0d cnt %0d want 0/17", state, step_cnt); end
        release_btns();
        n_checks++; if (step_cnt !== 16'd17) begin n_fail++; $display("FAIL pause_held: got %0d want 17", step_cnt); end
        press_and_hold(1'b1, 1'b1);
        n_checks++; if (state !== 3'd1) begin n_fail++; $display("FAIL both_press: got state %0d want 1", state); end
        release_btns();
        do_clr();
    endtask

    task automatic test_async_reset();
        press_and_hold(1'b1, 1'b0);
        btn_run = 1'b0;
        repeat (3) tick();
        n_checks++; if (state !== 3'd1 || cpu_en !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got state %0d en %b want 1/1", state, cpu_en); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (cpu_en !== 1'b0 || state !== 3'd0) begin n_fail++; $display("FAIL ar_async: got en %b state %0d want 0/0", cpu_en, state); end
        n_checks++; if (step_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_cnt: got %0d want 0", step_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        n_checks++; if (state !== 3'd0 || step_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_after: got state %0d cnt %0d want 0/0", state, step_cnt); end
    endtask

    initial begin
        rst_n    = 1'b0;
        btn_run  = 1'b0;
        btn_step = 1'b0;
        clr      = 1'b0;
        comp     = 1'b0;
        test_reset();
        test_debounce();
        test_step();
        test_run_comp();
        test_clr_priority();
        test_timeout();
        test_pause();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run/halt/single-step sequencer for the puzzle-solver CPU. It debounces two raw board buttons (run, step) and produces a one-bit execution enable, `cpu_en`, that gates `pc_we`, `reg_we` and `mem_we` at the decoder outputs. It stops execution when the register file asserts `comp`, or when a cycle budget is exhausted. It sits between the board inputs, the `register` block's `comp` flag and the decoder write enables, and runs on the divided `clk`.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable synchronized samples required to accept a button level change; must be ≥1.
- `CNT_W`, default 16: width of `step_cnt`.
- `TIMEOUT`, default 1000: maximum enabled cycles before the block enters FAULT; must satisfy 1 ≤ TIMEOUT < 2^CNT_W.
- `clk` in 1: divided system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_run` in 1: raw run/pause button, active high, asynchronous.
- `btn_step` in 1: raw single-step button, active high, asynchronous.
- `clr` in 1: synchronous clear, active high, one or more cycles.
- `comp` in 1: puzzle-solved flag from `register`, synchronous to `clk`.
- `cpu_en` out 1: execution enable, ANDed with `pc_we`, `reg_we` and `mem_we`.
- `state` out 3: current FSM state (IDLE=0, RUN=1, STEP=2, DONE=3, FAULT=4).
- `step_cnt` out CNT_W: number of cycles in which `cpu_en` was 1 since reset or clear.
- `done` out 1: high while in DONE.
- `fault` out 1: high while in FAULT.

## Operation
- **Debounce** (per button): two-flop synchronizer feeding sample `s`; register `stable` holds the accepted level; counter `dcnt` holds the mismatch count.
  - When `s==stable`: `dcnt<=0`.
  - Otherwise, when `dcnt==DEB_CYCLES-1`: `stable<=s`, `dcnt<=0`. Else `dcnt<=dcnt+1`.
  - Press event `*_pr = stable & ~stable_d`: a one-cycle pulse. Releases generate no event.
- **Enable:** `cpu_en = (state==RUN || state==STEP) && !comp`. It is combinational from registered state and `comp`.
- **Counter:** `step_cnt` increments by 1 on every edge where `cpu_en==1`. It does not wrap, because FAULT is reached first.
- **FSM** (transition priority top to bottom in each state):
  - **Any state:** `clr` → IDLE, with `step_cnt<=0`.
  - **IDLE:** `run_pr` → RUN; else `step_pr` → STEP. If both pulse in the same cycle, run wins.
  - **RUN:**
    - `comp` → DONE.
    - `cpu_en && step_cnt+1==TIMEOUT` → FAULT.
    - `run_pr` → IDLE (pause; `step_cnt` is held).
    - `step_pr` is ignored.
  - **STEP:** `comp` → DONE; `step_cnt+1==TIMEOUT` → FAULT; else → IDLE. STEP therefore enables exactly one cycle.
  - **DONE:** hold until `clr`. Button presses are ignored.
  - **FAULT:** hold until `clr`. Button presses are ignored.
- Entering RUN or STEP while `comp==1` produces no enabled cycle and moves to DONE on the next edge.
- `done` and `fault` are decoded from `state`.

## Timing
- Reset (async, `rst_n=0`) sets: `state`=IDLE, `cpu_en`=0, `step_cnt`=0, `done`=0, `fault`=0. Synchronizers, `stable`, `stable_d` and `dcnt` all reset to 0.
- Button latency: raw rising before edge e1 → `s`=1 after e2 → `stable`=1 after edge e(2+DEB_CYCLES) → `*_pr` high for that cycle → FSM changes state at e(3+DEB_CYCLES). With the default DEB_CYCLES=4, that is edge e7.
- A raw glitch shorter than DEB_CYCLES cycles at `s` produces no event. Holding a button produces exactly one event.
- RUN: `cpu_en` is 1 in the first cycle after entry and in every following cycle until exit. Pause takes effect at the edge where `run_pr` is sampled, so that cycle is still enabled.
- `comp` rising: `cpu_en` drops in the same cycle, and `state`=DONE after the next edge.
- FAULT: the TIMEOUT-th enabled cycle is the last one. `step_cnt`=TIMEOUT and `state`=FAULT after that edge.
- `clr` coinciding with `comp` or a timeout: `clr` wins, giving IDLE with `step_cnt`=0. If `cpu_en` was 1 in that cycle, the count is discarded.
- Reset asserted mid-RUN: outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- **Debounce:** DEB_CYCLES=4. Pulse `btn_run` high for 3 cycles → `state` stays 0. Hold it high 10 cycles → `state`=1 exactly at edge 7 after the rise, and one transition only.
- **Step:** from IDLE, one `btn_step` press → `cpu_en`=1 for exactly 1 cycle, `step_cnt`=1, `state` returns to 0. Three presses → `step_cnt`=3.
- **Run to completion:** press run, and force `comp`=1 after 25 enabled cycles → `cpu_en`=0 that cycle, `state`=3, `done`=1, `step_cnt`=25. Further button presses leave the state unchanged.
- **Timeout:** TIMEOUT=50, run with `comp`=0 → `step_cnt`=50, `state`=4, `fault`=1, `cpu_en`=0 afterwards. `clr` → `state`=0, `step_cnt`=0.
- **Pause/resume and simultaneous press:** run, then press run again after 10 cycles → IDLE with `step_cnt` held at its value. Press run and step in the same cycle → `state`=1.
- **Async reset:** drop `rst_n` mid-RUN between clock edges → `cpu_en`=0, `state`=0, `step_cnt`=0 before the next edge.
